// File: rtl/colony_scheduler_if.sv
// Shared widths for the ant array and the scheduler's bus interface.
// The setup channel (loader -> scheduler) and the world-memory write port
// (scheduler -> world memory) are grouped here so both ends bind to one bundle.
package colony_params;
    localparam int X_bits   = 8;
    localparam int Y_bits   = 7;
    // colony(1) + mouth(1) + dir(2) + X + Y
    localparam int ANT_bits = 1 + 1 + 2 + X_bits + Y_bits;
endpackage

// Handshake semantics for both channels: a transfer happens on a rising
// game_clk edge where the offering side's valid/req and the accepting side's
// ready/ack are both high. The offering side keeps its payload stable until
// that edge. wr_ack is ignored in any cycle where wr_req is low.
interface colony_scheduler_if;
    logic                                setup_valid;
    logic [colony_params::ANT_bits-1:0]  setup_data;
    logic                                setup_ready;
    logic                                wr_req;
    logic [colony_params::X_bits-1:0]    wr_X;
    logic [colony_params::Y_bits-1:0]    wr_Y;
    logic                                wr_op;
    logic                                wr_ack;

    // Scheduler side: accepts ant records, issues world writes.
    modport slave (
        input  setup_valid, setup_data, wr_ack,
        output setup_ready, wr_req, wr_X, wr_Y, wr_op
    );

    // Environment side: the init loader and the world memory.
    modport master (
        output setup_valid, setup_data, wr_ack,
        input  setup_ready, wr_req, wr_X, wr_Y, wr_op
    );
endinterface

// File: rtl/colony_scheduler.sv
// colony_scheduler: loads every ant during setup, then runs one simulation
// step per frame tick. A step snapshots each ant's sugar event, serialises
// the events onto the single world-memory write port (lowest ant index
// first), pulses moveNow, then pulses global_writing_flag to re-arm the ants.
module colony_scheduler #(
    parameter int NUM_ANTS = 8,
    parameter int IDX_W    = $clog2(NUM_ANTS)
) (
    input  logic                                    game_clk,
    input  logic                                    RESET,
    colony_scheduler_if.slave                       bus,
    output logic                                    SETUP_PHASE,
    output logic [NUM_ANTS-1:0]                     ant_SET,
    output logic [colony_params::ANT_bits-1:0]      ant_D_IN,
    input  logic                                    frame_tick,
    input  logic                                    pause,
    input  logic [NUM_ANTS-1:0]                     ant_collecting,
    input  logic [NUM_ANTS-1:0]                     ant_dropping,
    input  logic [NUM_ANTS*colony_params::X_bits-1:0] ant_X,
    input  logic [NUM_ANTS*colony_params::Y_bits-1:0] ant_Y,
    output logic                                    moveNow,
    output logic                                    global_writing_flag,
    output logic [15:0]                             step_count,
    output logic                                    tick_overrun,
    output logic [2:0]                              state_dbg
);

    localparam int XB = colony_params::X_bits;
    localparam int YB = colony_params::Y_bits;

    typedef enum logic [2:0] {
        S_SETUP   = 3'd0,
        S_PRIME   = 3'd1,
        S_WAIT    = 3'd2,
        S_SNAP    = 3'd3,
        S_DRAIN   = 3'd4,
        S_MOVE    = 3'd5,
        S_RELEASE = 3'd6
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_load_idx;
    logic [NUM_ANTS-1:0]  r_pending;
    logic [NUM_ANTS-1:0]  r_op_vec;
    logic                 r_tick_pend;
    logic                 r_tick_overrun;
    logic [15:0]          r_step_count;
    logic                 r_setup_ready;
    logic                 r_setup_phase;
    logic                 r_move_now;
    logic                 r_gw_flag;
    logic                 r_wr_req;
    logic                 r_wr_op;
    logic [IDX_W-1:0]     r_wr_idx;
    logic [XB-1:0]        r_wr_x;
    logic [YB-1:0]        r_wr_y;

    logic                 w_setup_hs;
    logic                 w_wr_fire;
    logic                 w_step_state;
    logic [NUM_ANTS-1:0]  w_snap_pend;
    logic [NUM_ANTS-1:0]  w_ack_mask;
    logic [NUM_ANTS-1:0]  w_drain_left;
    logic [NUM_ANTS-1:0]  w_sel_src;
    logic                 w_sel_any;
    logic [IDX_W-1:0]     w_sel_idx;
    logic                 w_sel_op;
    logic [XB-1:0]        w_sel_x;
    logic [YB-1:0]        w_sel_y;

    // The record is accepted whenever the loader offers one during SETUP.
    assign w_setup_hs   = (r_state == S_SETUP) && bus.setup_valid;
    // An ack only counts while a request is actually outstanding.
    assign w_wr_fire    = r_wr_req && bus.wr_ack;
    // Ticks arriving in these states are remembered for the next WAIT_TICK.
    assign w_step_state = (r_state == S_SNAP) || (r_state == S_DRAIN) ||
                          (r_state == S_MOVE) || (r_state == S_RELEASE);
    assign w_snap_pend  = ant_collecting | ant_dropping;

    // Pending set after removing the ant whose write is accepted this cycle.
    always_comb begin
        w_ack_mask = '0;
        if (w_wr_fire) begin
            w_ack_mask[r_wr_idx] = 1'b1;
        end
        w_drain_left = r_pending & ~w_ack_mask;
    end

    // Pick the lowest-index ant still owing a write (live snapshot in SNAP).
    always_comb begin
        w_sel_src = (r_state == S_SNAP) ? w_snap_pend : w_drain_left;
        w_sel_any = 1'b0;
        w_sel_idx = '0;
        for (int i = NUM_ANTS - 1; i >= 0; i--) begin
            if (w_sel_src[i]) begin
                w_sel_any = 1'b1;
                w_sel_idx = IDX_W'(i);
            end
        end
    end

    // Payload of the selected ant; coordinates come straight from the ants,
    // which hold still until moveNow, so sampling them late is safe.
    always_comb begin
        w_sel_op = (r_state == S_SNAP) ? ant_dropping[w_sel_idx] : r_op_vec[w_sel_idx];
        w_sel_x  = ant_X[int'(w_sel_idx) * XB +: XB];
        w_sel_y  = ant_Y[int'(w_sel_idx) * YB +: YB];
    end

    // Load strobe follows setup_valid in the same cycle so the ant latches
    // the broadcast record on the handshake edge.
    always_comb begin
        ant_SET = '0;
        if (w_setup_hs) begin
            ant_SET[r_load_idx] = 1'b1;
        end
    end

    // Sequencer: setup load, priming, per-frame step, write serialisation.
    always_ff @(posedge game_clk or posedge RESET) begin
        if (RESET) begin
            r_state        <= S_SETUP;
            r_load_idx     <= '0;
            r_pending      <= '0;
            r_op_vec       <= '0;
            r_tick_pend    <= 1'b0;
            r_tick_overrun <= 1'b0;
            r_step_count   <= 16'd0;
            r_setup_ready  <= 1'b1;
            r_setup_phase  <= 1'b1;
            r_move_now     <= 1'b0;
            r_gw_flag      <= 1'b0;
            r_wr_req       <= 1'b0;
            r_wr_op        <= 1'b0;
            r_wr_idx       <= '0;
            r_wr_x         <= '0;
            r_wr_y         <= '0;
        end else begin
            // Strobes are single-cycle unless a transition re-asserts them.
            r_move_now <= 1'b0;
            r_gw_flag  <= 1'b0;

            if (frame_tick && w_step_state) begin
                if (r_tick_pend) begin
                    r_tick_overrun <= 1'b1;
                end else begin
                    r_tick_pend <= 1'b1;
                end
            end

            case (r_state)
                S_SETUP: begin
                    if (w_setup_hs) begin
                        if (r_load_idx == IDX_W'(NUM_ANTS - 1)) begin
                            r_load_idx    <= '0;
                            r_setup_ready <= 1'b0;
                            r_gw_flag     <= 1'b1;
                            r_state       <= S_PRIME;
                        end else begin
                            r_load_idx <= r_load_idx + 1'b1;
                        end
                    end
                end

                S_PRIME: begin
                    // Ants have left WAIT_FOR_WRITE; setup is over.
                    r_setup_phase <= 1'b0;
                    r_state       <= S_WAIT;
                end

                S_WAIT: begin
                    // Ticks seen while paused are simply not acted upon.
                    if ((frame_tick || r_tick_pend) && !pause) begin
                        r_tick_pend <= 1'b0;
                        r_state     <= S_SNAP;
                    end
                end

                S_SNAP: begin
                    r_pending <= w_snap_pend;
                    r_op_vec  <= ant_dropping;
                    r_wr_req  <= w_sel_any;
                    r_wr_idx  <= w_sel_idx;
                    r_wr_op   <= w_sel_op;
                    r_wr_x    <= w_sel_x;
                    r_wr_y    <= w_sel_y;
                    r_state   <= S_DRAIN;
                end

                S_DRAIN: begin
                    if (r_pending == '0) begin
                        r_wr_req   <= 1'b0;
                        r_move_now <= 1'b1;
                        r_state    <= S_MOVE;
                    end else begin
                        // Re-selecting every cycle keeps the payload stable
                        // while unacked and advances right after an ack.
                        r_pending <= w_drain_left;
                        r_wr_req  <= w_sel_any;
                        r_wr_idx  <= w_sel_idx;
                        r_wr_op   <= w_sel_op;
                        r_wr_x    <= w_sel_x;
                        r_wr_y    <= w_sel_y;
                    end
                end

                S_MOVE: begin
                    r_gw_flag    <= 1'b1;
                    r_step_count <= r_step_count + 16'd1;
                    r_state      <= S_RELEASE;
                end

                S_RELEASE: begin
                    r_state <= S_WAIT;
                end

                default: begin
                    r_state <= S_SETUP;
                end
            endcase
        end
    end

    assign bus.setup_ready     = r_setup_ready;
    assign bus.wr_req          = r_wr_req;
    assign bus.wr_X            = r_wr_x;
    assign bus.wr_Y            = r_wr_y;
    assign bus.wr_op           = r_wr_op;
    assign ant_D_IN            = bus.setup_data;
    assign SETUP_PHASE         = r_setup_phase;
    assign moveNow             = r_move_now;
    assign global_writing_flag = r_gw_flag;
    assign step_count          = r_step_count;
    assign tick_overrun        = r_tick_overrun;
    assign state_dbg           = r_state;

endmodule
